// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues in-order word reads,
// buffers PC-tagged responses in a small queue and hands them to decode.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

    logic [31:0]   req_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW-1:0] count;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];

    logic [31:0]   target;
    logic          unused_redirect_bits;
    logic          req_fire;
    logic          push;
    logic          pop;
    logic [CW-1:0] outstanding_next;

    assign target               = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_bits = ^redirect_pc[1:0];

    // Credits cover both in-flight reads and queued words, so a response always has a slot.
    assign mem_req_valid = !rst && !redirect_valid
                           && (({1'b0, outstanding} + {1'b0, count}) < CREDITS);
    assign mem_req_addr  = req_pc;

    assign req_fire = mem_req_valid && mem_req_ready;
    assign push     = mem_resp_valid && (drop == '0) && !redirect_valid;
    assign pop      = if_valid && if_ready;

    assign outstanding_next = outstanding + CW'(req_fire) - CW'(mem_resp_valid);

    assign if_valid = (count != '0);
    assign if_pc    = q_pc[head];
    assign if_instr = q_instr[head];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_pc      <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
            // NOTE: the queue storage is reset because its head entry drives
            // if_pc/if_instr directly and those must read zero out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
            end
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old path.
                req_pc  <= target;
                resp_pc <= target;
                drop    <= outstanding_next;
                count   <= '0;
                head    <= '0;
                tail    <= '0;
            end else begin
                if (req_fire) begin
                    req_pc <= req_pc + 32'd4;
                end
                if (mem_resp_valid && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
                if (push) begin
                    q_pc[tail]    <= resp_pc;
                    q_instr[tail] <= mem_resp_data;
                    tail          <= tail + AW'(1);
                    resp_pc       <= resp_pc + 32'd4;
                end
                if (pop) begin
                    head <= head + AW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a latency-randomised memory model
// and a PC-stream reference (target, then +4 per delivered word) checked per cycle.
module tb_instr_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_ready       (if_ready)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        pending[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    int          delivered;
    int          req_count;
    int          first_req_cyc;
    int          first_val_cyc;
    bit          prev_valid;
    bit          prev_ready;
    logic [31:0] prev_addr;
    bit          just_reset;
    bit          coinc_hit;
    int          rdy_pct = 100;
    int          lat_lo = 1;
    int          lat_hi = 1;
    logic [31:0] redir_seq [2];
    int          post_idx = 2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        if_ready       = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_req_addr", mem_req_addr, RESET_PC);
        check("rst_if_valid", if_valid, 0);
        check("rst_if_instr", if_instr, 0);
        check("rst_if_pc", if_pc, 0);
        pending.delete();
        exp_pc        = RESET_PC;
        exp_req       = RESET_PC;
        delivered     = 0;
        req_count     = 0;
        first_req_cyc = -1;
        first_val_cyc = -1;
        prev_valid    = 1'b0;
        just_reset    = 1'b1;
        post_idx      = 2;
    endtask

    // One clock cycle: drive inputs, let outputs settle, compare, update the model.
    task automatic step(input bit rdr, input logic [31:0] tgt, input bit ifr, input bit rdr_coinc);
        bit resp_now;
        @(negedge clk);
        rst            = 1'b0;
        redirect_valid = rdr;
        redirect_pc    = tgt;
        mem_req_ready  = ($urandom_range(99) < rdy_pct);
        if_ready       = ifr;
        resp_now       = (pending.size() > 0) && (pending[0].due <= cyc);
        mem_resp_valid = resp_now;
        mem_resp_data  = resp_now ? mem_fn(pending[0].addr) : $urandom();
        #1;
        if (rdr_coinc && !rdr && resp_now && if_valid && if_ready) begin
            redirect_valid = 1'b1;
            coinc_hit      = 1'b1;
            #1;
        end
        if (just_reset) begin
            check("first_req_valid", mem_req_valid, 1);
            just_reset = 1'b0;
        end
        if (if_valid && first_val_cyc < 0) first_val_cyc = cyc;
        if (if_valid && if_ready) begin
            check("if_pc", if_pc, exp_pc);
            check("if_instr", if_instr, mem_fn(if_pc));
            if (post_idx < 2) begin
                redir_seq[post_idx] = if_pc;
                post_idx++;
            end
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
        if (redirect_valid) begin
            check("req_valid_in_redirect", mem_req_valid, 0);
            exp_pc   = {redirect_pc[31:2], 2'b00};
            exp_req  = exp_pc;
            post_idx = 0;
        end else begin
            if (prev_valid && !prev_ready) begin
                check("req_hold_valid", mem_req_valid, 1);
                check("req_hold_addr", mem_req_addr, prev_addr);
            end
            if (mem_req_valid) begin
                check("req_addr", mem_req_addr, exp_req);
                check("credit", pending.size() < DEPTH, 1);
            end
            if (mem_req_valid && mem_req_ready) begin
                pending.push_back('{addr: mem_req_addr, due: cyc + $urandom_range(lat_hi, lat_lo)});
                exp_req = exp_req + 32'd4;
                req_count++;
                if (first_req_cyc < 0) first_req_cyc = cyc;
            end
        end
        prev_valid = mem_req_valid && !redirect_valid;
        prev_ready = mem_req_ready;
        prev_addr  = mem_req_addr;
        if (resp_now) void'(pending.pop_front());
        cyc++;
    endtask

    initial begin
        int n;

        // Streaming with ready memory, latency 1, decode always ready.
        do_reset();
        rdy_pct = 100; lat_lo = 1; lat_hi = 1;
        repeat (20) step(0, '0, 1, 0);
        check("first_latency", first_val_cyc - first_req_cyc, 2);
        check("stream_progress", delivered >= 8, 1);

        // Decode stalled: credits cap the number of issued requests.
        do_reset();
        repeat (10) step(0, '0, 0, 0);
        check("stall_req_count", req_count, DEPTH);
        check("stall_req_valid", mem_req_valid, 0);
        check("stall_if_valid", if_valid, 1);
        repeat (30) step(0, '0, 1, 0);
        check("resume_progress", delivered >= 10, 1);

        // Redirect with two reads in flight; both must be discarded.
        do_reset();
        lat_lo = 5; lat_hi = 5;
        n = 0;
        while (pending.size() < 2 && n < 20) begin
            step(0, '0, 1, 0);
            n++;
        end
        check("redir_two_outstanding", pending.size(), 2);
        step(1, 32'h0000_0103, 1, 0);
        repeat (30) step(0, '0, 1, 0);
        check("redir_first_pc", redir_seq[0], 32'h0000_0100);
        check("redir_second_pc", redir_seq[1], 32'h0000_0104);

        // Redirect coinciding with a response and a decode handshake.
        do_reset();
        lat_lo = 1; lat_hi = 1;
        coinc_hit = 1'b0;
        n = 0;
        while (!coinc_hit && n < 40) begin
            step(0, 32'h0000_2000, 1, 1);
            n++;
        end
        check("coinc_hit", coinc_hit, 1);
        repeat (20) step(0, '0, 1, 0);
        check("coinc_first_pc", redir_seq[0], 32'h0000_2000);

        // Random backpressure, latency and redirects.
        do_reset();
        rdy_pct = 50; lat_lo = 1; lat_hi = 5;
        for (int i = 0; i < 2000; i++) begin
            bit          rdr;
            logic [31:0] tgt;
            rdr = ($urandom_range(39) == 0);
            tgt = $urandom();
            step(rdr, tgt, $urandom_range(3) != 0, $urandom_range(19) == 0);
        end
        check("random_progress", delivered >= 200, 1);

        // Wrap of the fetch PC at the top of the address space.
        lat_lo = 1; lat_hi = 3;
        step(1, 32'hFFFF_FFFE, 1, 0);
        repeat (40) step(0, '0, 1, 0);
        check("wrap_first_pc", redir_seq[0], 32'hFFFF_FFFC);
        check("wrap_second_pc", redir_seq[1], 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
